xor_frame_checksum: RTL and testbench



---
 rtl/xor_frame_checksum.sv | 129 ++++++++++++
 tb/tb_xor_frame_checksum.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/xor_frame_checksum.sv
// Streaming XOR checksum: folds a valid/ready frame of WIDTH-bit words into one
// checksum with parity, a saturating beat count and an overflow flag. The result is held until the consumer accepts it.
module xor_frame_checksum #(
    parameter  int WIDTH      = 8,
    parameter  int MAX_WORDS  = 16,
    parameter  int ODD_PARITY = 0,
    localparam int CW         = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
    localparam logic          PAR_INV = (ODD_PARITY != 0);

    function automatic logic parity_f(input logic [WIDTH-1:0] value);
        return (^value) ^ PAR_INV;
    endfunction

    state_t              state_r,    state_s;
    logic [WIDTH-1:0]    acc_r,      acc_s;
    logic [CW-1:0]       cnt_r,      cnt_s;
    logic                ovf_r,      ovf_s;
    logic [WIDTH-1:0]    sum_r,      sum_s;
    logic                par_r,      par_s;
    logic [CW-1:0]       ocnt_r,     ocnt_s;
    logic                oovf_r,     oovf_s;

    logic                accept_s;
    logic [WIDTH-1:0]    acc_x_s;
    logic                cnt_sat_s;
    logic [CW-1:0]       cnt_inc_s;
    logic                ovf_inc_s;

    // out_valid is a pure decode of the state register; in_ready must never look at in_valid
    assign out_valid    = (state_r == ST_HOLD);
    assign in_ready     = !out_valid;
    assign out_sum      = sum_r;
    assign out_parity   = par_r;
    assign out_count    = ocnt_r;
    assign out_overflow = oovf_r;

    assign accept_s  = in_valid && in_ready;
    assign acc_x_s   = acc_r ^ in_data;
    assign cnt_sat_s = (cnt_r == CNT_MAX);
    assign cnt_inc_s = cnt_sat_s ? cnt_r : (cnt_r + CW'(1));
    assign ovf_inc_s = ovf_r | cnt_sat_s;

    // Next-state and next-register values for the accumulate/hold FSM
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        sum_s   = sum_r;
        par_s   = par_r;
        ocnt_s  = ocnt_r;
        oovf_s  = oovf_r;
        case (state_r)
            ST_ACCUM: begin
                if (accept_s && in_last) begin
                    sum_s   = acc_x_s;
                    par_s   = parity_f(acc_x_s);
                    ocnt_s  = cnt_inc_s;
                    oovf_s  = ovf_inc_s;
                    acc_s   = {WIDTH{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    ovf_s   = 1'b0;
                    state_s = ST_HOLD;
                end else if (accept_s) begin
                    acc_s = acc_x_s;
                    cnt_s = cnt_inc_s;
                    ovf_s = ovf_inc_s;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACCUM;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            par_r   <= 1'b0;
            ocnt_r  <= {CW{1'b0}};
            oovf_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
            sum_r   <= sum_s;
            par_r   <= par_s;
            ocnt_r  <= ocnt_s;
            oovf_r  <= oovf_s;
        end
    end

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum: an even-parity instance with MAX_WORDS=4
// and an odd-parity instance with default sizing.
module tb_xor_frame_checksum;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, in_last, out_valid, out_ready;
    logic [7:0] in_data, out_sum;
    logic       out_parity, out_overflow;
    logic [2:0] out_count;

    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_sum;
    logic       b_out_parity, b_out_overflow;
    logic [4:0] b_out_count;

    int n_cmp;
    int n_bad;

    xor_frame_checksum #(.WIDTH(8), .MAX_WORDS(4), .ODD_PARITY(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_parity(out_parity), .out_count(out_count), .out_overflow(out_overflow)
    );

    xor_frame_checksum #(.WIDTH(8), .MAX_WORDS(16), .ODD_PARITY(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_parity(b_out_parity), .out_count(b_out_count), .out_overflow(b_out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] sum, input logic par,
                                input logic [2:0] cnt, input logic ovf);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, "_sum"}, {24'd0, out_sum}, {24'd0, sum});
        check_val({tag, "_par"}, {31'd0, out_parity}, {31'd0, par});
        check_val({tag, "_cnt"}, {29'd0, out_count}, {29'd0, cnt});
        check_val({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, ovf});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0; b_out_ready = 1'b1;
        #12;
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_sum", {24'd0, out_sum}, 32'd0);
        check_val("rst_cnt", {29'd0, out_count}, 32'd0);
        check_val("rst_ovf", {31'd0, out_overflow}, 32'd0);
        check_val("rst_par_b", {31'd0, b_out_parity}, 32'd0);
        rst_n = 1'b1;
        step();

        // three-beat frame
        send_beat(8'h0F, 1'b0);
        send_beat(8'hF0, 1'b0);
        send_beat(8'h3C, 1'b1);
        check_result("f3", 8'hC3, 1'b0, 3'd4 - 3'd1, 1'b0);
        check_val("f3_inrdy", {31'd0, in_ready}, 32'd0);
        step();
        check_val("f3_done", {31'd0, out_valid}, 32'd0);
        check_val("f3_rdy", {31'd0, in_ready}, 32'd1);

        // single-beat frame
        send_beat(8'hA5, 1'b1);
        check_result("single", 8'hA5, 1'b0, 3'd1, 1'b0);
        step();

        // backpressure with in_valid held high
        out_ready = 1'b0;
        send_beat(8'h81, 1'b1);
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_inrdy", {31'd0, in_ready}, 32'd0);
            check_result("bp", 8'h81, 1'b0, 3'd1, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        check_val("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        check_val("bp_release_vld", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0; in_last = 1'b0;
        step();

        // overflow: six beats on a MAX_WORDS=4 instance
        for (int i = 0; i < 5; i++) send_beat(8'h01, 1'b0);
        send_beat(8'h01, 1'b1);
        check_result("ovf", 8'h00, 1'b0, 3'd4, 1'b1);
        step();
        send_beat(8'h02, 1'b1);
        check_result("post_ovf", 8'h02, 1'b1, 3'd1, 1'b0);
        step();

        // reset mid-frame
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check_val("mid_rst_vld2", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        send_beat(8'h55, 1'b1);
        check_result("after_rst", 8'h55, 1'b0, 3'd1, 1'b0);
        step();

        // back-to-back frames, out_ready high, in_valid held
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        step();
        check_result("b2b_1", 8'hFF, 1'b0, 3'd1, 1'b0);
        check_val("b2b_gap", {31'd0, in_ready}, 32'd0);
        in_data = 8'h0F; in_last = 1'b0;
        step();
        check_val("b2b_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_data = 8'h01; in_last = 1'b1;
        step();
        check_result("b2b_2", 8'h0E, 1'b1, 3'd2, 1'b0);
        in_valid = 1'b0; in_last = 1'b0;
        step();

        // odd-parity instance
        b_in_valid = 1'b1; b_in_data = 8'h01; b_in_last = 1'b1;
        step();
        b_in_valid = 1'b0;
        check_val("odd_vld", {31'd0, b_out_valid}, 32'd1);
        check_val("odd_sum", {24'd0, b_out_sum}, 32'h01);
        check_val("odd_par_01", {31'd0, b_out_parity}, 32'd0);
        check_val("odd_cnt", {27'd0, b_out_count}, 32'd1);
        step();
        b_in_valid = 1'b1; b_in_data = 8'h03; b_in_last = 1'b1;
        step();
        b_in_valid = 1'b0;
        check_val("odd_par_03", {31'd0, b_out_parity}, 32'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
